// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Round-robin grant, registered ALU inputs, per-port held results.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req0_valid,
    input  logic [WIDTH-1:0] i_req0_a,
    input  logic [WIDTH-1:0] i_req0_b,
    input  logic [3:0]       i_req0_mode,
    output logic             o_req0_ready,
    input  logic             i_req1_valid,
    input  logic [WIDTH-1:0] i_req1_a,
    input  logic [WIDTH-1:0] i_req1_b,
    input  logic [3:0]       i_req1_mode,
    output logic             o_req1_ready,
    output logic             o_rsp0_valid,
    output logic [WIDTH-1:0] o_rsp0_data,
    input  logic             i_rsp0_ready,
    output logic             o_rsp1_valid,
    output logic [WIDTH-1:0] o_rsp1_data,
    input  logic             i_rsp1_ready,
    output logic [WIDTH-1:0] o_alu_data_1,
    output logic [WIDTH-1:0] o_alu_data_2,
    output logic [3:0]       o_alu_mode,
    input  logic [WIDTH-1:0] i_alu_data,
    output logic             o_busy
);

    logic             busy_q;
    logic             owner_q;
    logic             last_q;
    logic [1:0]       rsp_valid_q;
    logic [1:0]       rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q [2];
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [3:0]       alu_mode_q;

    logic             elig0;
    logic             elig1;
    logic             gnt_vld;
    logic             gnt_port;

    // A port may issue only when it has no result held and nothing in flight.
    always_comb begin
        elig0    = i_req0_valid && !rsp_valid_q[0] && !(busy_q && !owner_q);
        elig1    = i_req1_valid && !rsp_valid_q[1] && !(busy_q && owner_q);
        gnt_vld  = elig0 || elig1;
        gnt_port = (elig0 && elig1) ? !last_q : elig1;
    end

    assign o_req0_ready = gnt_vld && !gnt_port;
    assign o_req1_ready = gnt_vld && gnt_port;

    // Result-valid next state: consumer handshake clears, ALU capture sets.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        if (o_rsp0_valid && i_rsp0_ready) begin
            rsp_valid_d[0] = 1'b0;
        end
        if (o_rsp1_valid && i_rsp1_ready) begin
            rsp_valid_d[1] = 1'b0;
        end
        if (busy_q) begin
            rsp_valid_d[owner_q] = 1'b1;
        end
    end

    // Issue side: latch the granted operation into the ALU input registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_q     <= 1'b0;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_mode_q <= '0;
        end else if (gnt_vld) begin
            busy_q     <= 1'b1;
            owner_q    <= gnt_port;
            last_q     <= gnt_port;
            alu_a_q    <= gnt_port ? i_req1_a : i_req0_a;
            alu_b_q    <= gnt_port ? i_req1_b : i_req0_b;
            alu_mode_q <= gnt_port ? i_req1_mode : i_req0_mode;
        end else begin
            busy_q     <= 1'b0;
        end
    end

    // Response side: capture the ALU result for the owner and hold it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsp_valid_q   <= '0;
            rsp_data_q[0] <= '0;
            rsp_data_q[1] <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            if (busy_q) begin
                rsp_data_q[owner_q] <= i_alu_data;
            end
        end
    end

    assign o_rsp0_valid = rsp_valid_q[0];
    assign o_rsp1_valid = rsp_valid_q[1];
    assign o_rsp0_data  = rsp_data_q[0];
    assign o_rsp1_data  = rsp_data_q[1];
    assign o_alu_data_1 = alu_a_q;
    assign o_alu_data_2 = alu_b_q;
    assign o_alu_mode   = alu_mode_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for the shared-ALU arbiter.
// A transaction-level model predicts grants, ALU inputs and responses.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        v   [2];
    logic [31:0] a   [2];
    logic [31:0] b   [2];
    logic [3:0]  m   [2];
    logic        rdy [2];
    logic        rsp_v [2];
    logic [31:0] rsp_d [2];
    logic        rr  [2];
    logic [31:0] alu_d1;
    logic [31:0] alu_d2;
    logic [3:0]  alu_md;
    logic [31:0] alu_res;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] data;
        int          vis;
    } exp_t;

    exp_t        sbq0 [$];
    exp_t        sbq1 [$];
    bit          outst [2];
    int          last_g;
    bit          busy_exp;
    logic [31:0] exp_a1;
    logic [31:0] exp_a2;
    logic [3:0]  exp_md;
    logic [31:0] last_rsp [2];
    int          glog [$];

    alu_arbiter #(.WIDTH(32)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req0_valid (v[0]),
        .i_req0_a     (a[0]),
        .i_req0_b     (b[0]),
        .i_req0_mode  (m[0]),
        .o_req0_ready (rdy[0]),
        .i_req1_valid (v[1]),
        .i_req1_a     (a[1]),
        .i_req1_b     (b[1]),
        .i_req1_mode  (m[1]),
        .o_req1_ready (rdy[1]),
        .o_rsp0_valid (rsp_v[0]),
        .o_rsp0_data  (rsp_d[0]),
        .i_rsp0_ready (rr[0]),
        .o_rsp1_valid (rsp_v[1]),
        .o_rsp1_data  (rsp_d[1]),
        .i_rsp1_ready (rr[1]),
        .o_alu_data_1 (alu_d1),
        .o_alu_data_2 (alu_d2),
        .o_alu_mode   (alu_md),
        .i_alu_data   (alu_res),
        .o_busy       (busy)
    );

    // Behavioural ALU: the block under test only routes its operands.
    function automatic logic [31:0] alu_f(logic [31:0] x, logic [31:0] y,
                                          logic [3:0] md);
        case (md)
            4'b0000: return x + y;
            4'b0001: return x - y;
            4'b0010: return x << y[4:0];
            4'b0011: return x >> y[4:0];
            4'b0100: return x ^ y;
            4'b0110: return x | y;
            4'b0111: return x & y;
            4'b1011: return $signed(x) >>> y[4:0];
            default: return ~(x ^ y) + {28'd0, md};
        endcase
    endfunction

    always_comb alu_res = alu_f(alu_d1, alu_d2, alu_md);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic int qsize(int k);
        return (k == 0) ? sbq0.size() : sbq1.size();
    endfunction

    // Monitor: transaction-level model of grants, issue regs and responses.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sbq0.delete();
                sbq1.delete();
                outst[0] = 0;
                outst[1] = 0;
                last_g   = 1;
                busy_exp = 0;
                exp_a1   = '0;
                exp_a2   = '0;
                exp_md   = '0;
            end else begin
                int   g;
                bit   e0;
                bit   e1;
                exp_t fr;
                bit   expv;
                e0 = v[0] && !outst[0];
                e1 = v[1] && !outst[1];
                g  = -1;
                if (e0 && e1) g = (last_g == 1) ? 0 : 1;
                else if (e0)  g = 0;
                else if (e1)  g = 1;
                check("req0_ready", 32'(rdy[0]), 32'(g == 0));
                check("req1_ready", 32'(rdy[1]), 32'(g == 1));
                check("busy", 32'(busy), 32'(busy_exp));
                check("alu_data_1", alu_d1, exp_a1);
                check("alu_data_2", alu_d2, exp_a2);
                check("alu_mode", 32'(alu_md), 32'(exp_md));
                for (int k = 0; k < 2; k++) begin
                    expv = 0;
                    if (qsize(k) > 0) begin
                        fr   = (k == 0) ? sbq0[0] : sbq1[0];
                        expv = (cyc >= fr.vis);
                    end
                    check($sformatf("rsp%0d_valid", k), 32'(rsp_v[k]),
                          32'(expv));
                    if (expv) begin
                        check($sformatf("rsp%0d_data", k), rsp_d[k], fr.data);
                        if (rr[k]) begin
                            last_rsp[k] = rsp_d[k];
                            outst[k]    = 0;
                            if (k == 0) void'(sbq0.pop_front());
                            else        void'(sbq1.pop_front());
                        end
                    end
                end
                busy_exp = (g >= 0);
                if (g >= 0) begin
                    fr.data = alu_f(a[g], b[g], m[g]);
                    fr.vis  = cyc + 2;
                    if (g == 0) sbq0.push_back(fr);
                    else        sbq1.push_back(fr);
                    outst[g] = 1;
                    last_g   = g;
                    exp_a1   = a[g];
                    exp_a2   = b[g];
                    exp_md   = m[g];
                    glog.push_back(g);
                end
            end
        end
    end

    // Present one request on port p and hold it until the grant edge.
    task automatic issue(input int p, input logic [31:0] xa,
                         input logic [31:0] xb, input logic [3:0] xm,
                         output int waited, output int acc);
        bit ok;
        v[p]   = 1'b1;
        a[p]   = xa;
        b[p]   = xb;
        m[p]   = xm;
        waited = 0;
        acc    = -1;
        ok     = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (rdy[p]) begin
                ok  = 1;
                acc = cyc;
                break;
            end
            waited++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: port %0d never granted", p);
        end
        @(posedge clk);
        #1;
        v[p] = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        rr[0] = 1'b1;
        rr[1] = 1'b1;
        ok = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (sbq0.size() == 0 && sbq1.size() == 0 && !outst[0] &&
                !outst[1]) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: responses outstanding");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        v[0]  = 1'b0;
        v[1]  = 1'b0;
        @(negedge clk);
        check("rst_rsp0_valid", 32'(rsp_v[0]), 32'd0);
        check("rst_rsp1_valid", 32'(rsp_v[1]), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rsp0_data", rsp_d[0], 32'd0);
        check("rst_rsp1_data", rsp_d[1], 32'd0);
        check("rst_alu_d1", alu_d1, 32'd0);
        check("rst_alu_d2", alu_d2, 32'd0);
        check("rst_alu_mode", 32'(alu_md), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    int w0, w1, acc0, acc1, acc2, rise, maxw, done;

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            v[k] = 0; a[k] = 0; b[k] = 0; m[k] = 0; rr[k] = 1;
        end
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single add on port 0.
        issue(0, 32'd5, 32'd3, 4'b0000, w0, acc0);
        check("add_wait", 32'(w0), 32'd0);
        drain();
        check("add_result", last_rsp[0], 32'd8);

        // Simultaneous requests after reset: port 0 first.
        do_reset();
        fork
            issue(0, 32'd5, 32'd3, 4'b0000, w0, acc0);
            issue(1, 32'd3, 32'd5, 4'b0001, w1, acc1);
        join
        drain();
        check("simul_order", 32'(acc1 - acc0), 32'd1);
        check("simul_rsp0", last_rsp[0], 32'd8);
        check("simul_rsp1", last_rsp[1], 32'hFFFF_FFFE);

        // Sustained contention: grants alternate, waits stay short.
        glog.delete();
        maxw = 0;
        fork
            for (int i = 0; i < 6; i++) begin
                issue(0, $urandom, $urandom, 4'($urandom_range(0, 15)),
                      w0, acc0);
                if (w0 > maxw) maxw = w0;
            end
            for (int i = 0; i < 6; i++) begin
                issue(1, $urandom, $urandom, 4'($urandom_range(0, 15)),
                      w1, acc1);
                if (w1 > maxw) maxw = w1;
            end
        join
        drain();
        check("contend_maxwait_le2", 32'(maxw <= 2), 32'd1);
        begin
            int alt;
            alt = 1;
            for (int i = 1; i < glog.size(); i++)
                if (glog[i] == glog[i-1]) alt = 0;
            check("contend_alternate", 32'(alt), 32'd1);
            check("contend_grants", 32'(glog.size()), 32'd12);
        end

        // Backpressure on port 0 while port 1 keeps issuing.
        rr[0] = 1'b0;
        rr[1] = 1'b1;
        fork
            begin
                issue(0, 32'hF0, 32'h3C, 4'b0111, w0, acc0);
                issue(0, 32'd1, 32'd1, 4'b0000, w0, acc2);
            end
            begin
                for (int i = 0; i < 4; i++)
                    issue(1, $urandom, $urandom, 4'b0110, w1, acc1);
                @(negedge clk);
                check("bp_hold_valid", 32'(rsp_v[0]), 32'd1);
                check("bp_hold_data", rsp_d[0], 32'h30);
                check("bp_ready0_low", 32'(rdy[0]), 32'd0);
                @(posedge clk);
                #1;
                rr[0] = 1'b1;
                rise  = cyc;
            end
        join
        check("bp_release", 32'(acc2 - rise), 32'd1);
        drain();

        // Arithmetic shift right passes through on port 1.
        issue(1, 32'hFFFF_FF01, 32'd2, 4'b1011, w1, acc1);
        drain();
        check("sra_result", last_rsp[1], 32'hFFFF_FFC0);

        // Reset the cycle after an accept: the result must never appear.
        issue(0, 32'd7, 32'd9, 4'b0000, w0, acc0);
        do_reset();
        repeat (3) begin
            @(negedge clk);
            check("rst_no_rsp0", 32'(rsp_v[0]), 32'd0);
        end
        @(posedge clk);
        #1;
        glog.delete();
        fork
            issue(0, 32'd1, 32'd2, 4'b0000, w0, acc0);
            issue(1, 32'd3, 32'd4, 4'b0000, w1, acc1);
        join
        drain();
        check("rst_first_grant", 32'(glog[0]), 32'd0);

        // Randomized traffic with random response backpressure.
        done = 0;
        fork
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                issue(0, $urandom, $urandom, 4'($urandom_range(0, 15)),
                      w0, acc0);
            end
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                issue(1, $urandom, $urandom, 4'($urandom_range(0, 15)),
                      w1, acc1);
            end
            while (done < 1) begin
                @(posedge clk);
                #1;
                rr[0] = 1'($urandom_range(0, 1));
                rr[1] = 1'($urandom_range(0, 1));
                if (cyc > 40000) done = 1;
            end
        join_any
        wait fork;
        done = 1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
